// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: request side (a, b, func) and
// registered result side (out plus flags), each with valid/ready.
interface alu_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [FUNC_W-1:0] func;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out;
    logic              zero_flag;
    logic              neg_flag;
    logic              carry_flag;
    logic              ovf_flag;
    logic              busy;

    modport master (
        output in_valid, a, b, func, out_ready,
        input  in_ready, out_valid, out, zero_flag, neg_flag, carry_flag, ovf_flag, busy
    );

    modport slave (
        input  in_valid, a, b, func, out_ready,
        output in_ready, out_valid, out, zero_flag, neg_flag, carry_flag, ovf_flag, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; one-cycle ops plus an
// iterative shift-add multiply taking WIDTH cycles.
//   state | meaning
//   IDLE  | no result held, ready for an operation
//   MUL   | shift-add multiply in progress, input stalled
//   DONE  | result and flags presented, waiting for out_ready
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 4,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] F_NOR  = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_SLL  = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_SRL  = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_SRA  = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] F_SLT  = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] F_SLTU = FUNC_W'(9);
    localparam logic [FUNC_W-1:0] F_XOR  = FUNC_W'(10);
    localparam logic [FUNC_W-1:0] F_MUL  = FUNC_W'(11);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_nxt;
    logic               accept, load_res, load_mul, mul_done;
    logic [WIDTH:0]     add_full, sub_full;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [2*WIDTH-1:0] acc, mcand, acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == MUL);
    assign accept        = bus.in_valid && bus.in_ready;

    assign add_full = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_full = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = bus.b[SHW-1:0];
    assign acc_sum  = acc + (mplier[0] ? mcand : '0);
    assign mul_done = (state == MUL) && (cnt == CNT_W'(1));

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.func)
            F_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (add_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            F_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (sub_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            F_AND:  alu_res = bus.a & bus.b;
            F_OR:   alu_res = bus.a | bus.b;
            F_NOR:  alu_res = ~(bus.a | bus.b);
            F_SLL:  alu_res = bus.a << shamt;
            F_SRL:  alu_res = bus.a >> shamt;
            F_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
            F_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                alu_c   = sub_full[WIDTH];
            end
            F_SLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
                alu_c   = sub_full[WIDTH];
            end
            F_XOR:  alu_res = bus.a ^ bus.b;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_res  = 1'b0;
        load_mul  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (bus.func == F_MUL) begin
                        load_mul  = 1'b1;
                        state_nxt = MUL;
                    end else begin
                        load_res  = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (state == DONE && bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            MUL: if (mul_done) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            cnt            <= '0;
            bus.out        <= '0;
            bus.zero_flag  <= 1'b0;
            bus.neg_flag   <= 1'b0;
            bus.carry_flag <= 1'b0;
            bus.ovf_flag   <= 1'b0;
        end else begin
            if (load_mul) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, bus.a};
                mplier <= bus.b;
                cnt    <= CNT_W'(WIDTH);
            end else if (state == MUL) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end
            if (load_res) begin
                bus.out        <= alu_res;
                bus.zero_flag  <= (alu_res == '0);
                bus.neg_flag   <= alu_res[WIDTH-1];
                bus.carry_flag <= alu_c;
                bus.ovf_flag   <= alu_v;
            end else if (mul_done) begin
                // final add folded in so the product lands on the WIDTH-th edge
                bus.out        <= acc_sum[WIDTH-1:0];
                bus.zero_flag  <= (acc_sum[WIDTH-1:0] == '0);
                bus.neg_flag   <= acc_sum[WIDTH-1];
                bus.carry_flag <= |acc_sum[2*WIDTH-1:WIDTH];
                bus.ovf_flag   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: reset, single-cycle ops back-to-back, compares,
// multiply latency, backpressure and reset during a multiply.
module tb_alu_pipe;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    alu_pipe_if #(.WIDTH(32), .FUNC_W(4)) bus ();

    alu_pipe #(.WIDTH(32), .FUNC_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {bus.zero_flag, bus.neg_flag, bus.carry_flag, bus.ovf_flag};
    endfunction

    // drives one op, checks acceptance, then checks the result one edge later
    task automatic op_chk(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out, input logic [3:0] exp_fl);
        bus.func = f; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        tick();
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_out"}, bus.out, exp_out);
        chk({tag, "_flg"}, 32'(flags()), 32'(exp_fl));
    endtask

    task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_out, input logic [3:0] exp_fl);
        int bad;
        bad = 0;
        bus.func = 4'd11; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        tick();
        // in_valid stays high with a different op to show it is ignored
        bus.func = 4'd0; bus.a = 32'h1; bus.b = 32'h1;
        for (int i = 0; i < 32; i++) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            if (i == 31) bus.in_valid = 1'b0;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(bad), 32'd0);
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, "_out"}, bus.out, exp_out);
        chk({tag, "_flg"}, 32'(flags()), 32'(exp_fl));
    endtask

    initial begin
        int bad;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.func = 4'd0; bus.a = 32'd1; bus.b = 32'd2; bus.out_ready = 1'b1;

        tick(); tick();
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_out", bus.out, 32'd0);
        chk("rst_flg", 32'(flags()), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 32'(bus.in_ready), 32'd1);

        // flags packed as {zero, neg, carry, ovf}
        op_chk("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0101);
        op_chk("sub_eq",   4'd1,  32'd5,         32'd5,         32'h0,         4'b1010);
        op_chk("sra",      4'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 4'b0100);
        op_chk("add_cy",   4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1010);
        op_chk("sub_brw",  4'd1,  32'h0,         32'h1,         32'hFFFF_FFFF, 4'b0100);
        op_chk("sub_ovf",  4'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0011);
        op_chk("and",      4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 4'b0000);
        op_chk("or",       4'd3,  32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 4'b0100);
        op_chk("nor",      4'd4,  32'h0,         32'h0,         32'hFFFF_FFFF, 4'b0100);
        op_chk("sll",      4'd5,  32'h1,         32'h21,        32'h2,         4'b0000);
        op_chk("srl",      4'd6,  32'h8000_0000, 32'h1F,        32'h1,         4'b0000);
        op_chk("slt",      4'd8,  32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0010);
        op_chk("sltu",     4'd9,  32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1010);
        op_chk("slt_pos",  4'd8,  32'h1,         32'h2,         32'h1,         4'b0000);
        op_chk("f14",      4'd14, 32'h1234_5678, 32'h1,         32'h0,         4'b1000);
        bus.in_valid = 1'b0;
        tick();
        chk("drain_vld", 32'(bus.out_valid), 32'd0);

        mul_run("mul_big", 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b1010);
        mul_run("mul_small", 32'd123, 32'd456, 32'd56088, 4'b0000);
        tick();
        chk("mul_idle", 32'(bus.out_valid), 32'd0);

        // backpressure
        bus.out_ready = 1'b0;
        op_chk("xor", 4'd10, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 4'b0100);
        bus.func = 4'd0; bus.a = 32'd3; bus.b = 32'd4; bus.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out !== 32'hAAAA_AAAA || flags() !== 4'b0100 ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            tick();
        end
        chk("bp_hold", 32'(bad), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bp_next_vld", 32'(bus.out_valid), 32'd1);
        chk("bp_next_out", bus.out, 32'd7);
        bus.in_valid = 1'b0;
        tick();

        // reset during multiply
        bus.func = 4'd11; bus.a = 32'd3; bus.b = 32'd5; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("mr_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_vld", 32'(bus.out_valid), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_out", bus.out, 32'd0);
        rst_n = 1'b1;
        op_chk("mr_add", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000);
        bus.in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.out !== 32'd5) bad++;
        end
        chk("mr_no_stale", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Registered, parametrised successor to the team's combinational ALU.
- Accepts one operation per handshake and returns a registered result plus status flags.
- Extends the function set with right shifts, compares, XOR and an iterative multiply.
- Sits between the datapath register-read stage and writeback, with valid/ready flow control on both sides.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, power of 2)
FUNC_W, 4, width of the func select
SHW, $clog2(WIDTH), derived; number of b bits used as shift amount

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
func  input  FUNC_W  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts the result
out  output  WIDTH  registered result
zero_flag  output  1  out == 0
neg_flag  output  1  out[WIDTH-1]
carry_flag  output  1  carry/no-borrow/multiply-overflow
ovf_flag  output  1  signed overflow
busy  output  1  multiply in progress

Behaviour:
Reset
- rst_n=0 at a clock edge forces state IDLE; out_valid=0, out=0, all flags 0, busy=0.
- Reset mid-multiply aborts the multiply. Its result is never presented.

Func encoding (all arithmetic modulo 2^WIDTH)
- 0 add
- 1 sub (a-b)
- 2 and
- 3 or
- 4 nor
- 5 sll
- 6 srl
- 7 sra
- 8 slt (signed, result 1/0)
- 9 sltu
- 10 xor
- 11 mul (low WIDTH bits, unsigned)
- 12-15: out=0, all flags 0 except zero_flag=1.
- Shifts use only b[SHW-1:0]; upper b bits are ignored.

Handshake
- Transfer in: in_valid && in_ready at a rising edge. Operands and func are captured at that edge.
- Transfer out: out_valid && out_ready at a rising edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- While out_valid=1 and out_ready=0: out and all flags hold stable, and in_ready=0.

FSM states: IDLE, MUL, DONE
- IDLE: on accept of a non-mul op, register result and flags, go to DONE (out_valid=1 in the next cycle, latency 1). On accept of mul, load multiplicand/multiplier/accumulator and a counter of WIDTH, go to MUL, busy=1.
- MUL: shift-add, one multiplier bit per cycle. The counter decrements each cycle. After WIDTH cycles in MUL, register the product and flags and go to DONE. out_valid therefore rises WIDTH edges after the accept edge. in_ready=0 and in_valid is ignored throughout MUL.
- DONE: out_valid=1.
  - out_ready=1 with a new accept: behave as IDLE-accept, staying in DONE or going to MUL.
  - out_ready=1 with no new accept: go to IDLE, out_valid=0.
  - out_ready=0: hold.

Flags (registered with out; valid only when out_valid=1)
- zero_flag and neg_flag: apply to every func.
- carry_flag:
  - add: carry-out of a+b.
  - sub/slt/sltu: carry-out of a+~b+1 (1 means a>=b unsigned).
  - mul: 1 if any bit of the full 2*WIDTH product above WIDTH-1 is set.
  - all other funcs: 0.
- ovf_flag:
  - add: set when operand signs are equal and the result sign differs.
  - sub: set when operand signs differ and the result sign differs from a.
  - all other funcs: 0.

Test Plan:
1. Reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, out=0, flags=0, no transfer occurs. Release reset -> in_ready=1.
2. Single-cycle ops, out_ready tied 1, back-to-back:
   - add 0x7FFFFFFF+1 -> out=0x80000000, ovf=1, neg=1, carry=0.
   - sub 5-5 -> out=0, zero=1, carry=1.
   - sra 0x80000000 by b=0x24 (uses 4) -> out=0xF8000000.
   - Each result appears exactly 1 cycle after its accept, one result per cycle.
3. Compares: slt a=0xFFFFFFFF,b=1 -> out=1; sltu same operands -> out=0; func=14 -> out=0, zero=1.
4. Multiply:
   - 0x0001_0000 * 0x0001_0000 -> out=0, carry=1, zero=1. out_valid rises 32 edges after accept; busy=1 and in_ready=0 throughout.
   - 123*456 -> out=56088, carry=0.
5. Backpressure: out_ready=0 for 5 cycles after an xor result -> out and flags stable, in_ready=0. Raise out_ready with in_valid=1 -> completion and next accept happen on the same edge.
6. Reset mid-multiply: assert rst_n=0 at cycle 10 of a mul -> next cycle IDLE, out_valid=0, busy=0. A following add is accepted and completes correctly.
